cond_flag_unit: RTL
===================

Name: cond_flag_unit

Overview:
- Two-stage condition-evaluation and flag-write unit. It sits on both sides of the NZCV flag register.
- Reader side: evaluates the ARM 4-bit condition field of each issued instruction against the current flags (NZCV_REG Q) and produces COND_EX.
- Writer side: generates the per-bit EN and D that update NZCV_REG.
- Includes forwarding so back-to-back flag-setting and flag-reading instructions see correct flags.

Parameters:
- FLAG_WIDTH, 4, number of flag bits; fixed at 4; order [3]=N, [2]=Z, [1]=C, [0]=V.
- CNT_W, 16, width of the optional performance counters.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  instruction present this cycle.
- COND  input  4  ARM condition field.
- FLAG_W  input  2  flag-write request: [1] updates N,Z; [0] updates C,V.
- ALU_FLAGS  input  4  ALU result flags {N,Z,C,V}, aligned with IN_VALID.
- NZCV_Q  input  4  current NZCV_REG output.
- OUT_VALID  output  1  stage-1 entry valid.
- COND_EX  output  1  instruction in stage 1 executes.
- NZCV_EN  output  4  per-bit write enable to NZCV_REG.
- NZCV_D  output  4  write data to NZCV_REG.
- EXEC_CNT  output  CNT_W  executed-instruction count (COND_PERF_CNT_EN only).
- SQUASH_CNT  output  CNT_W  squashed-instruction count (COND_PERF_CNT_EN only).

Behaviour:
- Reset: one clock, one reset. Reset is synchronous and active-high. On RST high at a rising edge, all stage registers clear: OUT_VALID=0, COND_EX=0, NZCV_EN=4'b0000, NZCV_D=4'b0000, counters=0.
- A reset mid-operation drops every in-flight write; NZCV_REG receives no enable from this unit after the reset edge.
- Stage 1 (S1):
  - At each edge, capture IN_VALID, COND, FLAG_W, ALU_FLAGS.
  - OUT_VALID = S1 valid.
  - COND_EX is combinational from S1 and the effective flags, and is valid in the cycle after sampling (latency 1).
- Effective flags, per bit b: eff[b] = S2_EN[b] ? S2_D[b] : NZCV_Q[b]. This forwards a write that has not yet landed in NZCV_REG.
- Condition decode on eff:
  - 0000 EQ: Z. 0001 NE: !Z.
  - 0010 CS: C. 0011 CC: !C.
  - 0100 MI: N. 0101 PL: !N.
  - 0110 VS: V. 0111 VC: !V.
  - 1000 HI: C&!Z. 1001 LS: !C|Z.
  - 1010 GE: N==V. 1011 LT: N!=V.
  - 1100 GT: !Z&(N==V). 1101 LE: Z|(N!=V).
  - 1110 AL: 1. 1111: 1 (unconditional).
  - COND_EX = S1 valid & decode result.
- Stage 2 (S2): at each edge, capture
  - S2_EN = {FLAG_W[1],FLAG_W[1],FLAG_W[0],FLAG_W[0]} & {4{COND_EX}}.
  - S2_D = ALU_FLAGS from S1.
- NZCV_EN/NZCV_D are driven directly from S2 (latency 2 from input sampling). NZCV_REG captures them at the edge ending that cycle.
- Disabled bits:
  - NZCV_D carries the ALU value on all bits regardless.
  - Correctness relies on NZCV_EN masking.
  - Forwarding also uses NZCV_EN per bit, so partially enabled writes forward only the enabled bits.
- Bubbles: IN_VALID=0 gives S1 invalid, COND_EX=0, and NZCV_EN=0 one cycle later.
- A squashed instruction (COND_EX=0) never writes flags, even with FLAG_W!=0.
- Simultaneous events:
  - The instruction in S1 sees the S2 write via forwarding.
  - A write two instructions back is already in NZCV_Q.
  - No stall is ever required.

Optional Feature:
- Macro: COND_PERF_CNT_EN.
- Defined:
  - EXEC_CNT increments on every cycle with S1 valid and COND_EX=1.
  - SQUASH_CNT increments on every cycle with S1 valid and COND_EX=0.
  - Both wrap from all-ones to 0 and clear on RST.
- Undefined: both counter registers are absent, and EXEC_CNT/SQUASH_CNT are tied to 0.

Decomposition:
- Shared package holds:
  - Condition-code localparams (COND_EQ..COND_AL, COND_NV).
  - Flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
  - FLAG_W encoding constants.
- One natural sub-module: cond_check. It is purely combinational (COND, 4-bit flags -> pass), instantiated once on the effective flags.

Test Plan:
- Reset: RST=1 for 2 cycles with IN_VALID=1 and FLAG_W=2'b11 -> NZCV_EN=0000, OUT_VALID=0, counters 0.
- Write-then-read forwarding:
  - Cycle 0: COND=1110, FLAG_W=11, ALU_FLAGS=1010, NZCV_Q=0000.
  - Cycle 1: COND=0000 (EQ).
  - Required: first COND_EX=1; second COND_EX=0 (forwarded Z=0).
  - Repeat with ALU_FLAGS=0100 -> EQ COND_EX=1.
- Partial write:
  - NZCV_Q=0011; issue AL with FLAG_W=10, ALU_FLAGS=1100, then VS.
  - Required: NZCV_EN=1100, NZCV_D=1100, VS COND_EX=1 (V from NZCV_Q).
- Squash:
  - NZCV_Q=0100; issue NE with FLAG_W=11, ALU_FLAGS=1111.
  - Required: COND_EX=0, NZCV_EN stays 0000, SQUASH_CNT+1.
- All 16 conditions against NZCV_Q in {0000,0100,1001,0110,1010} -> COND_EX matches the decode table; bubbles (IN_VALID=0) give COND_EX=0 and NZCV_EN=0000.
- Reset mid-flight:
  - AL with FLAG_W=11 issued, RST asserted the following edge.
  - Required: NZCV_EN=0000 in the cycle the write would have appeared.

Source files
------------

// File: rtl/cond_flag_unit_pkg.sv
// Shared constants for the condition-evaluation / flag-write unit:
// ARM condition codes, NZCV bit positions and flag-write request encodings.
package cond_flag_unit_pkg;

    // ARM condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions inside a 4-bit NZCV vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Flag-write request: [1] selects N,Z; [0] selects C,V
    localparam logic [1:0] FLAG_W_NONE = 2'b00;
    localparam logic [1:0] FLAG_W_CV   = 2'b01;
    localparam logic [1:0] FLAG_W_NZ   = 2'b10;
    localparam logic [1:0] FLAG_W_ALL  = 2'b11;

    // Expand the 2-bit write request into a per-flag enable mask {N,Z,C,V}
    function automatic logic [3:0] expand_flag_w(input logic [1:0] fw);
        return {fw[1], fw[1], fw[0], fw[0]};
    endfunction

endpackage

// File: rtl/cond_flag_unit_cond_check.sv
// Purely combinational ARM condition-code evaluator: given a 4-bit condition
// field and an NZCV vector, reports whether the condition passes.
module cond_check
    import cond_flag_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n_f;
    logic z_f;
    logic c_f;
    logic v_f;

    assign n_f = flags[FLAG_N];
    assign z_f = flags[FLAG_Z];
    assign c_f = flags[FLAG_C];
    assign v_f = flags[FLAG_V];

    // Decode the condition field against the supplied flags
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z_f;
            COND_NE: pass = !z_f;
            COND_CS: pass = c_f;
            COND_CC: pass = !c_f;
            COND_MI: pass = n_f;
            COND_PL: pass = !n_f;
            COND_VS: pass = v_f;
            COND_VC: pass = !v_f;
            COND_HI: pass = c_f && !z_f;
            COND_LS: pass = !c_f || z_f;
            COND_GE: pass = (n_f == v_f);
            COND_LT: pass = (n_f != v_f);
            COND_GT: pass = !z_f && (n_f == v_f);
            COND_LE: pass = z_f || (n_f != v_f);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_flag_unit.sv
// Two-stage condition-evaluation and NZCV flag-write unit.
// Stage 1 holds the issued instruction and evaluates its condition against
// the effective flags (NZCV_Q with the pending stage-2 write forwarded per
// bit). Stage 2 holds the resulting per-bit write enable and ALU data that
// drive NZCV_REG directly.
// Optional build macro COND_PERF_CNT_EN adds executed/squashed counters;
// without it EXEC_CNT and SQUASH_CNT are tied to zero.
//
// Handshake: valid-only, no backpressure. IN_VALID marks an instruction on
// the inputs in that cycle; OUT_VALID marks the instruction held in stage 1.
// The unit never stalls, so there is no ready signal in either direction.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int FLAG_WIDTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    input  logic [3:0]            COND,
    input  logic [1:0]            FLAG_W,
    input  logic [FLAG_WIDTH-1:0] ALU_FLAGS,
    input  logic [FLAG_WIDTH-1:0] NZCV_Q,
    output logic                  OUT_VALID,
    output logic                  COND_EX,
    output logic [FLAG_WIDTH-1:0] NZCV_EN,
    output logic [FLAG_WIDTH-1:0] NZCV_D,
    output logic [CNT_W-1:0]      EXEC_CNT,
    output logic [CNT_W-1:0]      SQUASH_CNT
);

    // Stage 1 registers
    logic                  s1_valid;
    logic [3:0]            s1_cond;
    logic [1:0]            s1_flag_w;
    logic [FLAG_WIDTH-1:0] s1_alu;

    // Stage 2 registers
    logic [FLAG_WIDTH-1:0] s2_en;
    logic [FLAG_WIDTH-1:0] s2_d;

    logic [FLAG_WIDTH-1:0] eff_flags;
    logic                  cond_pass;
    logic                  cond_ex;

    // Stage 1 capture of the issued instruction
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s1_cond   <= 4'h0;
            s1_flag_w <= FLAG_W_NONE;
            s1_alu    <= '0;
        end else begin
            s1_valid  <= IN_VALID;
            s1_cond   <= COND;
            s1_flag_w <= FLAG_W;
            s1_alu    <= ALU_FLAGS;
        end
    end

    // Forward the pending stage-2 write bit by bit; disabled bits come from the register
    always_comb begin
        eff_flags = (s2_en & s2_d) | (~s2_en & NZCV_Q);
    end

    cond_check u_cond_check (
        .cond  (s1_cond),
        .flags (eff_flags),
        .pass  (cond_pass)
    );

    assign cond_ex = s1_valid && cond_pass;

    // Stage 2 capture: a squashed or invalid instruction produces no enables
    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_en <= '0;
            s2_d  <= '0;
        end else begin
            s2_en <= expand_flag_w(s1_flag_w) & {FLAG_WIDTH{cond_ex}};
            s2_d  <= s1_alu;
        end
    end

    assign OUT_VALID = s1_valid;
    assign COND_EX   = cond_ex;
    assign NZCV_EN   = s2_en;
    assign NZCV_D    = s2_d;

`ifdef COND_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] exec_cnt_q;
    logic [CNT_W-1:0] squash_cnt_q;

    // Count executed and squashed stage-1 instructions; both wrap naturally
    always_ff @(posedge CLK) begin
        if (RST) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else if (s1_valid) begin
            if (cond_ex) begin
                exec_cnt_q <= exec_cnt_q + CNT_ONE;
            end else begin
                squash_cnt_q <= squash_cnt_q + CNT_ONE;
            end
        end
    end

    assign EXEC_CNT   = exec_cnt_q;
    assign SQUASH_CNT = squash_cnt_q;
`else
    assign EXEC_CNT   = '0;
    assign SQUASH_CNT = '0;
`endif

endmodule
